// File: rtl/ccff_chain_programmer_if.sv
// Byte-stream handshake between the bitstream loader and the chain programmer.
interface ccff_chain_programmer_if;
   logic [7:0] byte_in;
   logic       byte_valid;
   logic       byte_ready;

   modport master (
      output byte_in,
      output byte_valid,
      input  byte_ready
   );

   modport slave (
      input  byte_in,
      input  byte_valid,
      output byte_ready
   );
endinterface

// File: rtl/ccff_chain_programmer.sv
// Serializes a host byte stream MSB-first onto a configuration chain head, gating the chain clock.
// Optional readback with CRC-16 comparison is enabled by defining CCFF_READBACK_EN.
module ccff_chain_programmer #(
   parameter int CHAIN_LEN = 20,
   parameter int CNT_W     = 16
) (
   input  logic              prog_clk,
   input  logic              prog_rst_n,
   input  logic              start,
   input  logic              abort,
   ccff_chain_programmer_if.slave byte_bus,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              shift_en,
   output logic              busy,
   output logic              done,
   output logic              verify_fail
);

`ifdef CCFF_READBACK_EN
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, VERIFY = 2'd2, DONE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd3} state_t;
`endif

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [7:0]       buf_q, buf_d;
   logic [3:0]       buf_cnt_q, buf_cnt_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             load_shift;
   logic             last_bit;
   logic             accept;

   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         state_q   <= IDLE;
         buf_q     <= '0;
         buf_cnt_q <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         buf_q     <= buf_d;
         buf_cnt_q <= buf_cnt_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   always_comb begin
      state_d             = state_q;
      buf_d               = buf_q;
      buf_cnt_d           = buf_cnt_q;
      bit_cnt_d           = bit_cnt_q;
      load_shift          = 1'b0;
      accept              = 1'b0;
      last_bit            = (bit_cnt_q == LAST_BIT);
      shift_en            = 1'b0;
      ccff_head           = 1'b0;
      busy                = 1'b1;
      done                = 1'b0;
      byte_bus.byte_ready = 1'b0;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_d   = LOAD;
               bit_cnt_d = '0;
               buf_cnt_d = '0;
               buf_d     = '0;
            end
         end
         LOAD: begin
            ccff_head  = buf_q[7];
            load_shift = (buf_cnt_q != 4'd0) && !abort;
            shift_en   = load_shift;
            // A fresh byte may land in the same cycle the last buffered bit leaves.
            byte_bus.byte_ready = !abort && !(load_shift && last_bit) &&
                                  ((buf_cnt_q == 4'd0) || (buf_cnt_q == 4'd1 && load_shift));
            accept = byte_bus.byte_valid && byte_bus.byte_ready;
            if (load_shift) begin
               buf_d     = {buf_q[6:0], 1'b0};
               buf_cnt_d = buf_cnt_q - 4'd1;
               bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
            if (accept) begin
               buf_d     = byte_bus.byte_in;
               buf_cnt_d = 4'd8;
            end
            if (abort) begin
               state_d = IDLE;
            end else if (load_shift && last_bit) begin
               // Leftover bits of a partial final byte are dropped here.
               buf_d     = '0;
               buf_cnt_d = '0;
               bit_cnt_d = '0;
`ifdef CCFF_READBACK_EN
               state_d   = VERIFY;
`else
               state_d   = DONE;
`endif
            end
         end
`ifdef CCFF_READBACK_EN
         VERIFY: begin
            // Recirculate tail into head so a full lap leaves the chain unchanged.
            ccff_head = ccff_tail;
            shift_en  = !abort;
            if (abort) begin
               state_d = IDLE;
            end else if (last_bit) begin
               state_d   = DONE;
               bit_cnt_d = '0;
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
         end
`endif
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef CCFF_READBACK_EN
   logic [15:0] tx_crc_q, rx_crc_q;
   logic        vfail_q;

   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
      logic fb;
      fb = crc[15] ^ b;
      return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         tx_crc_q <= 16'hFFFF;
         rx_crc_q <= 16'hFFFF;
         vfail_q  <= 1'b0;
      end else begin
         if (state_q == IDLE && start) begin
            tx_crc_q <= 16'hFFFF;
            rx_crc_q <= 16'hFFFF;
            vfail_q  <= 1'b0;
         end
         if (load_shift) tx_crc_q <= crc16_step(tx_crc_q, buf_q[7]);
         if (state_q == VERIFY && shift_en) begin
            rx_crc_q <= crc16_step(rx_crc_q, ccff_tail);
            if (last_bit) vfail_q <= (tx_crc_q != crc16_step(rx_crc_q, ccff_tail));
         end
      end
   end

   assign verify_fail = vfail_q;
`else
   // The tail is only observed by readback; without it the flag is a constant 0.
   assign verify_fail = ccff_tail & 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_programmer.sv
// Scoreboard bench for ccff_chain_programmer driving a 20-bit model chain.
module tb_ccff_chain_programmer;
   localparam int CHAIN_LEN = 20;
`ifdef CCFF_READBACK_EN
   localparam int NSH = 2 * CHAIN_LEN;
`else
   localparam int NSH = CHAIN_LEN;
`endif

   logic clk = 1'b0;
   logic prog_rst_n = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic ccff_head, ccff_tail, shift_en, busy, done, verify_fail;

   ccff_chain_programmer_if byte_bus ();

   ccff_chain_programmer #(.CHAIN_LEN(CHAIN_LEN), .CNT_W(16)) dut (
      .prog_clk   (clk),
      .prog_rst_n (prog_rst_n),
      .start      (start),
      .abort      (abort),
      .byte_bus   (byte_bus),
      .ccff_head  (ccff_head),
      .ccff_tail  (ccff_tail),
      .shift_en   (shift_en),
      .busy       (busy),
      .done       (done),
      .verify_fail(verify_fail)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic exp_q[$];
   int pass_shifts = 0;
   int first_shift = -1;
   int last_shift = -1;
   int done_cnt = 0;
   int done_cyc = -1;
   logic prev_done = 1'b0;

   // Model chain: bit 0 sits at the head, bit 19 at the tail.
   logic [19:0] chain = '0;
   int sh_cnt = 0;
   logic flip_arm = 1'b0;

   assign ccff_tail = chain[19];

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (start && !busy) begin
         sh_cnt <= 0;
      end else if (shift_en) begin
         chain  <= {chain[18:0], ccff_head} ^ ((flip_arm && sh_cnt == CHAIN_LEN - 1) ? 20'h1 : 20'h0);
         sh_cnt <= sh_cnt + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // Monitor: every shift pops one expected head bit.
   always @(negedge clk) begin
      if (shift_en === 1'b1) begin
         pass_shifts++;
         if (first_shift < 0) first_shift = cyc;
         last_shift = cyc;
         if (exp_q.size() == 0) chk("unexpected_shift", 0, 1);
         else chk("head_bit", ccff_head, exp_q.pop_front());
      end
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
         if (prev_done) chk("done_width", 2, 1);
      end
      prev_done = (done === 1'b1);
   end

   task automatic push_exp(input logic [19:0] v);
      for (int i = 19; i >= 0; i--) exp_q.push_back(v[i]);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      byte_bus.byte_in    = b;
      byte_bus.byte_valid = 1'b1;
      while (byte_bus.byte_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("byte_accept_timeout", n < 100, 1);
      @(negedge clk);
   endtask

   task automatic run_pass(input int gap, input logic flip, input string tag);
      logic [19:0] img;
      int t, dc0;
      img = 20'hA53CF;
      push_exp(img);
`ifdef CCFF_READBACK_EN
      push_exp(flip ? (img ^ 20'h1) : img);
`endif
      flip_arm    = flip;
      pass_shifts = 0;
      first_shift = -1;
      last_shift  = -1;
      dc0         = done_cnt;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy"}, busy, 1);
      send_byte(8'hA5);
      if (gap > 0) begin
         byte_bus.byte_valid = 1'b0;
         t = 0;
         while (!(byte_bus.byte_ready === 1'b1 && shift_en === 1'b0) && t < 50) begin
            @(negedge clk);
            t++;
         end
         for (int k = 0; k < gap; k++) begin
            chk({tag, "_gap_ready"}, byte_bus.byte_ready, 1);
            chk({tag, "_gap_shift"}, shift_en, 0);
            start = (k == 2);
            @(negedge clk);
         end
         start = 1'b0;
      end
      send_byte(8'h3C);
      send_byte(8'hF0);
      byte_bus.byte_valid = 1'b0;
      t = 0;
      while (done_cnt == dc0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(negedge clk);
      chk({tag, "_done_count"}, done_cnt - dc0, 1);
      chk({tag, "_done_latency"}, done_cyc - last_shift, 1);
      chk({tag, "_shift_count"}, pass_shifts, NSH);
      if (gap == 0) chk({tag, "_contiguous"}, last_shift - first_shift + 1, NSH);
      chk({tag, "_chain"}, chain, flip ? (img ^ 20'h1) : img);
      chk({tag, "_queue_empty"}, exp_q.size(), 0);
      chk({tag, "_idle_busy"}, busy, 0);
      chk({tag, "_verify_fail"}, verify_fail, flip);
      flip_arm = 1'b0;
   endtask

   initial begin
      int n, dc0;
      byte_bus.byte_in    = 8'h00;
      byte_bus.byte_valid = 1'b0;
      #2 prog_rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {byte_bus.byte_ready, ccff_head, shift_en, busy, done, verify_fail}, 0);
      prog_rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", byte_bus.byte_ready, 0);
      chk("idle_busy", busy, 0);

      run_pass(0, 1'b0, "stream");
      run_pass(5, 1'b0, "stall");

      // Abort after nine shifts.
      for (int i = 0; i < 9; i++) exp_q.push_back(i == 8 ? 1'b1 : 8'hA5 >> (7 - i));
      dc0 = done_cnt;
      start = 1'b1;
      byte_bus.byte_in    = 8'hA5;
      byte_bus.byte_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      for (int t = 0; t < 100 && n < 9; t++) begin
         @(negedge clk);
         if (shift_en === 1'b1) n++;
      end
      chk("abort_reached_nine", n, 9);
      @(posedge clk);
      #1 abort = 1'b1;
      @(negedge clk);
      chk("abort_shift_off", shift_en, 0);
      @(posedge clk);
      #1 abort = 1'b0;
      byte_bus.byte_valid = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_ready", byte_bus.byte_ready, 0);
      repeat (3) @(negedge clk);
      chk("abort_no_done", done_cnt - dc0, 0);
      chk("abort_queue", exp_q.size(), 0);

      run_pass(0, 1'b0, "restart");

      // Reset in the middle of a load.
      for (int i = 0; i < 4; i++) exp_q.push_back(8'hA5 >> (7 - i));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_byte(8'hA5);
      byte_bus.byte_valid = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 prog_rst_n = 1'b0;
      #1 chk("midreset_outputs", {byte_bus.byte_ready, ccff_head, shift_en, busy, done, verify_fail}, 0);
      @(negedge clk);
      prog_rst_n = 1'b1;
      @(negedge clk);
      chk("midreset_busy", busy, 0);
      chk("midreset_ready", byte_bus.byte_ready, 0);
      chk("midreset_queue", exp_q.size(), 0);

      run_pass(0, 1'b0, "after_reset");
`ifdef CCFF_READBACK_EN
      run_pass(0, 1'b1, "rb_flip");
      run_pass(0, 1'b0, "rb_clean");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/ccff_chain_programmer.md
Name: ccff_chain_programmer

Overview:
- Writer side of the configuration-chain protocol used by routing and logic tiles: a serial shift chain of `ccff_head` → mem cells → `ccff_tail`, clocked by `prog_clk`.
- Accepts a byte stream from the host/loader (valid/ready) and serializes it onto `ccff_head`.
- Drives a shift enable that gates `prog_clk` to the chain, so a data stall never corrupts chain contents.
- Sits between the bitstream source and the head of a tile chain, e.g. a switch block with 20 config bits.

Parameters:
- `CHAIN_LEN`, 20, total configuration bits in the downstream chain (≥1).
- `CNT_W`, 16, width of the bit counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- `prog_clk` input 1: programming clock.
- `prog_rst_n` input 1: asynchronous active-low reset.
- `start` input 1: pulse in IDLE to begin a programming pass.
- `abort` input 1: terminate the current pass and return to IDLE.
- `byte_in` input 8: configuration byte, MSB shifted first.
- `byte_valid` input 1: `byte_in` valid.
- `byte_ready` output 1: block accepts `byte_in` this cycle.
- `ccff_head` output 1: serial data into the chain head.
- `ccff_tail` input 1: serial data from the chain tail (used by the optional feature).
- `shift_en` output 1: chain clock enable; the chain shifts on the `prog_clk` edge ending a cycle with `shift_en`=1.
- `busy` output 1: pass in progress.
- `done` output 1: one-cycle pulse when the pass completes.
- `verify_fail` output 1: sticky readback mismatch flag (always 0 without the optional feature).

Behaviour:
- Reset (async assert, sync release): state=IDLE, `byte_ready`=0, `ccff_head`=0, `shift_en`=0, `busy`=0, `done`=0, `verify_fail`=0, counters=0, byte buffer empty.
- States: IDLE, LOAD, VERIFY (only with the optional feature), DONE.
- IDLE:
  - `start`=1 → LOAD.
  - On that transition: `bit_cnt`=0, buffer empty, `verify_fail` cleared.
  - `start` is ignored in any other state.
- LOAD, byte side:
  - `byte_ready`=1 when the 8-bit buffer is empty, or will empty this cycle (its last bit shifts out).
  - A byte is accepted on `byte_valid && byte_ready`.
- LOAD, shift side:
  - `shift_en` is combinational: (state==LOAD && buffer non-empty).
  - `ccff_head` = buffer MSB.
  - Each shift cycle: buffer shifts left, `bit_cnt` increments.
  - Buffer empty → `shift_en`=0 and the chain holds (stall); there is no bubble once data is available.
  - Back-to-back bytes stream one bit per cycle; a new byte loads in the same cycle the previous last bit shifts out.
- Completion:
  - When `bit_cnt` reaches `CHAIN_LEN` (on the edge of the final shift) → DONE, or VERIFY if enabled.
  - Remaining buffered bits of a partial final byte are discarded.
  - `byte_ready`=0 from that point on.
- Bit ordering: the first bit shifted ends at the chain tail; the last bit ends at the chain head.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `busy`=1 in LOAD/VERIFY/DONE.
- `abort` (any non-IDLE state): next cycle IDLE.
  - `shift_en` deasserts combinationally in the abort cycle; the chain holds its partial contents.
  - No `done` pulse.
  - `abort` has priority over completion in the same cycle.
- Reset mid-pass: immediate return to reset values; the chain is left partially loaded, and software must restart.

Optional Feature:
- Macro: `CCFF_READBACK_EN`.
- Defined:
  - During LOAD, bits sent on `ccff_head` feed a CRC-16 (poly 0x1021, init 0xFFFF, MSB-first) TX signature.
  - After LOAD → VERIFY for exactly `CHAIN_LEN` cycles with `shift_en`=1 and `ccff_head`=`ccff_tail` (recirculation, so chain contents are restored).
  - `ccff_tail` bits feed an RX CRC.
  - At the end of VERIFY: `verify_fail`=(TX≠RX), then DONE.
  - `done` latency is 2×`CHAIN_LEN`+stalls.
- Undefined: no VERIFY state, no CRC logic, `verify_fail` tied 0.

Test Plan:
- `CHAIN_LEN`=20; `start`; bytes 0xA5, 0x3C, 0xF0 with `byte_valid` held → 20 contiguous `shift_en` cycles; `ccff_head` sequence = 10100101 00111100 1111; `done` pulse 1 cycle after the last shift; a 20-bit model chain holds 0xA53CF.
- Same bytes with `byte_valid` low for 5 cycles between bytes 1 and 2 → `shift_en`=0 during the gap; chain content identical to the no-stall case; `byte_ready`=1 during the gap.
- `start` asserted while `busy` → ignored; `bit_cnt` unaffected.
- `abort` after 9 shifts → `shift_en`=0 that cycle; IDLE next cycle; no `done`; `busy`=0; a new `start` restarts with `bit_cnt`=0.
- `prog_rst_n` low mid-LOAD → all outputs 0 asynchronously; after release IDLE, `byte_ready`=0.
- `CCFF_READBACK_EN`, model chain: load 0xA5, 0x3C, 0xF0 → `verify_fail`=0 and chain still 0xA53CF after VERIFY; flip one bit in the model chain before VERIFY → `verify_fail`=1.
